// File: rtl/worm_nav_pkg.sv
// Shared encodings for the worm navigator: command directions, idle command, FSM states.
package worm_nav_pkg;

  localparam int W = 6;

  localparam logic [1:0] DIR_PX = 2'b00;
  localparam logic [1:0] DIR_NX = 2'b01;
  localparam logic [1:0] DIR_PY = 2'b10;
  localparam logic [1:0] DIR_NY = 2'b11;

  // +x by 0: the worm treats this as a no-op
  localparam logic [5:0] CMD_NOP = 6'b000000;

  typedef enum logic [2:0] {
    IDLE,
    MOVE_X,
    MOVE_Y,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/worm_nav_delta.sv
// Shortest wrapped distance on one axis: direction bit (1 = negative) and step count.
// Purely combinational; a half-grid tie resolves to the positive direction.
module worm_nav_delta #(
  parameter int W = 6
) (
  input  logic [W-1:0] shadow,
  input  logic [W-1:0] tgt,
  output logic         neg,
  output logic [W-1:0] steps
);

  localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] d;

  assign d = tgt - shadow;

  always_comb begin
    neg   = 1'b0;
    steps = d;
    if (d > HALF) begin
      neg   = 1'b1;
      steps = '0 - d;
    end
  end

endmodule

// File: rtl/worm_nav.sv
// Steers the worm to an accepted target on the shortest wrapped path, one command per cycle.
// First cmd one cycle after handshake; tgt_ready stays low from handshake until the done pulse.
module worm_nav
  import worm_nav_pkg::*;
#(
  parameter int W        = worm_nav_pkg::W,
  parameter int MAX_STEP = 15,
  parameter int CHK_LAT  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] tgt_x,
  input  logic [W-1:0] tgt_y,
  input  logic         tgt_valid,
  output logic         tgt_ready,
  input  logic [W-1:0] cur_x,
  input  logic [W-1:0] cur_y,
  output logic [5:0]   cmd,
  output logic         cmd_valid,
  output logic         done,
  output logic         err
);

  localparam int CW = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;
  localparam logic [W-1:0]  MAX_W    = W'(MAX_STEP);
  localparam logic [CW-1:0] CNT_LAST = CW'(CHK_LAT - 1);

  state_t        state, state_n;
  logic [W-1:0]  shadow_x, shadow_x_n, shadow_y, shadow_y_n;
  logic [W-1:0]  rem_x, rem_x_n, rem_y, rem_y_n;
  logic          neg_x, neg_x_n, neg_y, neg_y_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [5:0]    cmd_n;
  logic          cmd_valid_n, done_n, tgt_ready_n, err_n;

  logic          dx_neg, dy_neg;
  logic [W-1:0]  dx_steps, dy_steps;
  logic [W-1:0]  mag_x, mag_y;

  worm_nav_delta #(.W(W)) u_delta_x (
    .shadow (shadow_x),
    .tgt    (tgt_x),
    .neg    (dx_neg),
    .steps  (dx_steps)
  );

  worm_nav_delta #(.W(W)) u_delta_y (
    .shadow (shadow_y),
    .tgt    (tgt_y),
    .neg    (dy_neg),
    .steps  (dy_steps)
  );

  assign mag_x = (rem_x > MAX_W) ? MAX_W : rem_x;
  assign mag_y = (rem_y > MAX_W) ? MAX_W : rem_y;

  // Every output is computed here one cycle ahead and registered below.
  always_comb begin
    state_n     = state;
    shadow_x_n  = shadow_x;
    shadow_y_n  = shadow_y;
    rem_x_n     = rem_x;
    rem_y_n     = rem_y;
    neg_x_n     = neg_x;
    neg_y_n     = neg_y;
    cnt_n       = cnt;
    cmd_n       = CMD_NOP;
    cmd_valid_n = 1'b0;
    done_n      = 1'b0;
    tgt_ready_n = tgt_ready;
    err_n       = err;

    unique case (state)
      IDLE: begin
        if (tgt_valid && tgt_ready) begin
          rem_x_n     = dx_steps;
          neg_x_n     = dx_neg;
          rem_y_n     = dy_steps;
          neg_y_n     = dy_neg;
          cnt_n       = '0;
          tgt_ready_n = 1'b0;
          state_n     = MOVE_X;
        end
      end
      MOVE_X: begin
        if (rem_x == '0) begin
          state_n = MOVE_Y;
        end else begin
          cmd_n       = {(neg_x ? DIR_NX : DIR_PX), mag_x[3:0]};
          cmd_valid_n = 1'b1;
          rem_x_n     = rem_x - mag_x;
          shadow_x_n  = neg_x ? (shadow_x - mag_x) : (shadow_x + mag_x);
          if (rem_x_n == '0) state_n = MOVE_Y;
        end
      end
      MOVE_Y: begin
        if (rem_y == '0) begin
          state_n = CHECK;
        end else begin
          cmd_n       = {(neg_y ? DIR_NY : DIR_PY), mag_y[3:0]};
          cmd_valid_n = 1'b1;
          rem_y_n     = rem_y - mag_y;
          shadow_y_n  = neg_y ? (shadow_y - mag_y) : (shadow_y + mag_y);
          if (rem_y_n == '0) state_n = CHECK;
        end
      end
      CHECK: begin
        cnt_n = cnt + CW'(1);
        if (cnt == CNT_LAST) begin
          if ((cur_x != shadow_x) || (cur_y != shadow_y)) err_n = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        done_n      = 1'b1;
        tgt_ready_n = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shadow_x  <= '0;
      shadow_y  <= '0;
      rem_x     <= '0;
      rem_y     <= '0;
      neg_x     <= 1'b0;
      neg_y     <= 1'b0;
      cnt       <= '0;
      cmd       <= CMD_NOP;
      cmd_valid <= 1'b0;
      done      <= 1'b0;
      tgt_ready <= 1'b1;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      shadow_x  <= shadow_x_n;
      shadow_y  <= shadow_y_n;
      rem_x     <= rem_x_n;
      rem_y     <= rem_y_n;
      neg_x     <= neg_x_n;
      neg_y     <= neg_y_n;
      cnt       <= cnt_n;
      cmd       <= cmd_n;
      cmd_valid <= cmd_valid_n;
      done      <= done_n;
      tgt_ready <= tgt_ready_n;
      err       <= err_n;
    end
  end

endmodule

// File: doc/worm_nav.md
Name: worm_nav

Overview:
- Command-side counterpart to the worm mover. Accepts a target coordinate over a valid/ready handshake and emits the 6-bit movement commands that steer the worm there on the shortest wrapped path.
- Keeps a shadow copy of the worm position. When a move finishes, it checks that shadow against the position the worm reports back.
- Sits directly upstream of the worm: its cmd output drives the worm's 6-bit command input, and the worm's two coordinate outputs feed back into cur_x/cur_y.

Parameters:
- W, 6, coordinate width. The grid is 2^W per axis and wraps modulo 2^W.
- MAX_STEP, 15, largest magnitude carried by one command. Must be ≤ 15 to fit cmd[3:0].
- CHK_LAT, 2, cycles to wait after the last command before comparing cur_x/cur_y with the shadow.

Ports:
- clk  in  1  clock, rising-edge active
- rst  in  1  synchronous, active-high reset
- tgt_x  in  W  target x
- tgt_y  in  W  target y
- tgt_valid  in  1  target offered
- tgt_ready  out  1  block can accept a target
- cur_x  in  W  x reported by worm
- cur_y  in  W  y reported by worm
- cmd  out  6  worm command: [5:4] direction (00 +x, 01 −x, 10 +y, 11 −y), [3:0] step magnitude
- cmd_valid  out  1  cmd is a real move this cycle
- done  out  1  one-cycle pulse when a move completes
- err  out  1  sticky: shadow ≠ reported position at a check

Behaviour:
- Reset, clk edge with rst=1:
  - state=IDLE, shadow=(0,0).
  - cmd=6'b000000, cmd_valid=0, done=0, err=0, tgt_ready=1.
  - rst overrides everything, including a move in progress; no further commands issue.
- Idle command is 6'b000000, i.e. +x by 0, which the worm treats as a no-op. All outputs are registered.
- IDLE:
  - tgt_ready=1.
  - Handshake when tgt_valid and tgt_ready are both 1 at an edge: latch the target, compute the x and y deltas, go to MOVE_X. tgt_ready drops to 0 the following cycle.
- Delta rule, per axis:
  - d = (tgt − shadow) mod 2^W.
  - d=0: axis skipped.
  - 1 ≤ d ≤ 2^(W−1): positive direction, d steps. A tie at exactly 2^(W−1) goes positive.
  - Otherwise: negative direction, 2^W − d steps.
- MOVE_X:
  - Each cycle emit one command with magnitude min(remaining, MAX_STEP) and cmd_valid=1.
  - Subtract the magnitude from remaining; update shadow_x with wrap.
  - When remaining reaches 0, go to MOVE_Y.
  - The first command appears the cycle after the handshake.
  - If the x delta is 0, go to MOVE_Y with no command.
- MOVE_Y: same rule on the y axis using directions 10/11, then go to CHECK.
- CHECK:
  - cmd idles. Count CHK_LAT cycles, then compare cur_x/cur_y with the shadow.
  - On mismatch, set err. err clears only on rst.
  - Go to DONE.
- DONE: pulse done=1 for one cycle, return to IDLE.
- Zero-distance target: IDLE → MOVE_X → MOVE_Y → CHECK with no cmd_valid. done pulses 3+CHK_LAT cycles after the handshake.
- tgt_valid while busy is ignored, since tgt_ready=0. The upstream must hold the target until it is accepted.
- Number of commands per axis = ceil(steps / MAX_STEP).

Decomposition:
- Shared package:
  - direction encodings DIR_PX/DIR_NX/DIR_PY/DIR_NY;
  - CMD_NOP = 6'b000000;
  - the state enum (IDLE, MOVE_X, MOVE_Y, CHECK, DONE);
  - W.
- One natural sub-module, worm_nav_delta: combinational, takes shadow and target for one axis and returns direction bit and step count. Instantiate it twice, once per axis.

Test Plan:
- Reset, then target (20,3). Required cmd sequence is 0x0F, 0x05, 0x23, each with cmd_valid=1 on consecutive cycles. Then done, with shadow=(20,3) and err=0 when the real worm is attached.
- From (20,3), target (60,3): dx=40, so the negative direction with 24 steps. Required cmds are 0x1F then 0x19, no y commands, done, shadow=(60,3).
- From (0,0), target (32,0), the tie case. Required cmds are 0x0F, 0x0F, 0x02, all +x.
- Target equal to the current position. Required: no cmd_valid, done exactly 3+CHK_LAT cycles after the handshake, tgt_ready low throughout.
- Assert rst during MOVE_X of a 40-step move. Required: next cycle cmd=0x00, cmd_valid=0, tgt_ready=1, shadow=(0,0), and no done pulse.
- Force cur_x off by 1 during CHECK. Required: err=1 after the check and still 1 after a following good move; cleared only by rst.
